snn_step_scheduler: RTL and testbench
=====================================

// Module: snn_step_scheduler
// PURPOSE
//  Timestep controller for the SNN core. Divides clk into programmable timesteps and
//  accumulates input spikes over each step. Once per step it sweeps the shared
//  neuron-update datapath over every neuron, then commits the fired pattern to spikes_out.
//  Arbitrates the shared neuron/weight memory port: SPI config writes run only between sweeps.
// PARAMETERS
//  N_NEURONS   3           neurons swept per step (>=1)
//  N_INPUTS    3           external spike inputs
//  PERIOD_W    24          timestep counter width
//  DEF_PERIOD  24'd10_000  cycles per step when period==0
//  ADDR_W      4           config/memory address width
//  DATA_W      8           config/memory data width
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          async reset, active low
//  ena         in   1          1=timer runs; 0=timer frozen
//  period      in   PERIOD_W   cycles per step; 0 selects DEF_PERIOD
//  spikes_in   in   N_INPUTS   asynchronous spike pins
//  cfg_req     in   1          SPI config write request (level; held until cfg_gnt)
//  cfg_addr    in   ADDR_W     config address
//  cfg_wdata   in   DATA_W     config data
//  cfg_gnt     out  1          write accepted this cycle
//  mem_we      out  1          shared memory write strobe (==cfg_gnt)
//  mem_addr    out  ADDR_W     shared memory address (cfg_addr when mem_we)
//  mem_wdata   out  DATA_W     shared memory write data
//  upd_valid   out  1          neuron update request
//  upd_idx     out  $clog2(N_NEURONS)  neuron being updated
//  upd_spikes  out  N_INPUTS   input spikes frozen for this step
//  upd_ready   in   1          datapath accepts/completes update
//  upd_fire    in   1          neuron fired; sampled on upd_valid&upd_ready
//  spikes_out  out  N_NEURONS  registered fired pattern of last committed step
//  step_tick   out  1          1-cycle pulse at COMMIT
//  step_cnt    out  8          committed steps, wraps 255->0
//  busy        out  1          state != IDLE
//  overrun     out  1          sticky: a tick was lost
// BEHAVIOUR
//  Reset (async): all outputs 0, timer=0, acc=0, tick_pend=0, state=IDLE.
//  Inputs: 2-flop sync per bit, then acc |= sync each cycle (level OR over step).
//  Timer: counts while ena; at cnt>=eff_period-1 -> cnt=0, tick. Period change applies
//   immediately through the >= compare. period==1 gives a tick every cycle.
//  tick_pend set on tick, cleared on leaving IDLE. Tick while tick_pend=1 -> dropped,
//   overrun<=1, kept until reset.
//  FSM:
//   IDLE:    if tick_pend -> CAPTURE; else grant cfg: cfg_gnt=cfg_req (combinational).
//   CAPTURE: 1 cycle; upd_spikes<=acc|sync; acc<=0; next_out<=0; idx<=0 -> SWEEP.
//   SWEEP:   upd_valid=1, upd_idx=idx; on upd_ready: next_out[idx]<=upd_fire;
//            idx==N_NEURONS-1 -> COMMIT, else idx++. No timeout: waits on upd_ready.
//   COMMIT:  spikes_out<=next_out; step_cnt++; step_tick=1 -> IDLE.
//  Latency: tick_pend set -> first upd_valid = 2 cycles. With upd_ready tied 1,
//   tick -> step_tick = N_NEURONS+3 cycles.
//  Simultaneous tick and cfg_req in IDLE: tick_pend is not yet visible, so the config
//   write is granted that cycle; the sweep starts next cycle.
//  Config is never granted outside IDLE; cfg_req simply waits.
//  ena=0 mid-sweep: the sweep completes normally; only the timer freezes.
//  Async reset mid-sweep aborts the sweep; spikes_out returns to 0.
// STRUCTURE
//  Shared package snn_pkg: state enum {IDLE,CAPTURE,SWEEP,COMMIT}, DEF_PERIOD, ADDR_W, DATA_W.
//  Sub-module snn_step_timer (period counter + tick + ena gating). FSM, arbitration and
//   spike accumulator stay in this block.
// TESTING
//  1 period=8, upd_ready=1, fire=3'b101 -> step_tick every 8 cycles; spikes_out=101; step_cnt increments.
//  2 spikes_in[1] pulses 1 cycle mid-step -> upd_spikes=3'b010 next step, 3'b000 the step after.
//  3 cfg_req held from mid-SWEEP -> cfg_gnt=0 until the IDLE cycle after COMMIT, then exactly one grant
//    with mem_we=1 and mem_addr=cfg_addr.
//  4 upd_ready=0 for 20 cycles with period=8 -> overrun=1; after release, exactly one extra sweep.
//  5 period=0 -> step_tick spacing=DEF_PERIOD; ena=0 for 100 cycles -> spacing grows by 100.
//  6 rst_n low during SWEEP idx=1 -> all outputs 0 immediately (async); normal stepping after release.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and default constants for the SNN step scheduler slice.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SWEEP,
    COMMIT
  } state_t;

  localparam logic [23:0] DEF_PERIOD = 24'd10_000;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 8;

endpackage

// File: rtl/snn_step_scheduler_if.sv
// Config-write, shared-memory and neuron-update handshake bundle.
// The master modport is the scheduler side; the slave modport is the datapath/SPI side.
interface snn_step_scheduler_if #(
  parameter int unsigned N_NEURONS = 3,
  parameter int unsigned N_INPUTS  = 3,
  parameter int unsigned ADDR_W    = snn_pkg::ADDR_W,
  parameter int unsigned DATA_W    = snn_pkg::DATA_W
);
  import snn_pkg::*;

  localparam int unsigned IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic              cfg_req;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_gnt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic                upd_valid;
  logic [IDX_W-1:0]    upd_idx;
  logic [N_INPUTS-1:0] upd_spikes;
  logic                upd_ready;
  logic                upd_fire;

  modport master (
    input  cfg_req, cfg_addr, cfg_wdata, upd_ready, upd_fire,
    output cfg_gnt, mem_we, mem_addr, mem_wdata, upd_valid, upd_idx, upd_spikes
  );

  modport slave (
    output cfg_req, cfg_addr, cfg_wdata, upd_ready, upd_fire,
    input  cfg_gnt, mem_we, mem_addr, mem_wdata, upd_valid, upd_idx, upd_spikes
  );

endinterface

// File: rtl/snn_step_timer.sv
// Programmable timestep counter: emits a one-cycle tick every eff_period enabled cycles.
module snn_step_timer #(
  parameter int unsigned         PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] DEF_PERIOD = snn_pkg::DEF_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  import snn_pkg::*;

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] eff_period;

  // Period 0 selects the default; >= compare lets a shrinking period take effect at once.
  always_comb begin
    eff_period = (period == '0) ? DEF_PERIOD : period;
    tick       = ena && (cnt_q >= (eff_period - PERIOD_W'(1)));
  end

  // Counter advances only while enabled and restarts on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= tick ? '0 : cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// Timestep controller: accumulates input spikes, sweeps the shared neuron-update
// datapath once per step, commits the fired pattern, and grants config writes between sweeps.
module snn_step_scheduler #(
  parameter int unsigned         N_NEURONS  = 3,
  parameter int unsigned         N_INPUTS   = 3,
  parameter int unsigned         PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] DEF_PERIOD = snn_pkg::DEF_PERIOD,
  parameter int unsigned         ADDR_W     = snn_pkg::ADDR_W,
  parameter int unsigned         DATA_W     = snn_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [N_INPUTS-1:0]  spikes_in,
  snn_step_scheduler_if.master bus,
  output logic [N_NEURONS-1:0] spikes_out,
  output logic                 step_tick,
  output logic [7:0]           step_cnt,
  output logic                 busy,
  output logic                 overrun
);
  import snn_pkg::*;

  localparam int unsigned      IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t               state_q, state_d;
  logic [N_INPUTS-1:0]  sync1_q, sync2_q, acc_q, upd_spikes_q;
  logic [IDX_W-1:0]     idx_q;
  logic [N_NEURONS-1:0] next_out_q;
  logic                 tick, tick_pend_q, leave_idle, cfg_gnt_w;
  logic [ADDR_W-1:0]    mem_addr_w;
  logic [DATA_W-1:0]    mem_wdata_w;

  snn_step_timer #(
    .PERIOD_W  (PERIOD_W),
    .DEF_PERIOD(DEF_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .period(period),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; config is granted only in an IDLE cycle with no pending tick.
  always_comb begin
    state_d     = state_q;
    leave_idle  = 1'b0;
    cfg_gnt_w   = 1'b0;
    step_tick   = 1'b0;
    mem_addr_w  = '0;
    mem_wdata_w = '0;
    unique case (state_q)
      IDLE: begin
        if (tick_pend_q) begin
          state_d    = CAPTURE;
          leave_idle = 1'b1;
        end else begin
          cfg_gnt_w = bus.cfg_req;
        end
      end
      CAPTURE: state_d = SWEEP;
      SWEEP:   if (bus.upd_ready && idx_q == LAST_IDX) state_d = COMMIT;
      COMMIT: begin
        step_tick = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cfg_gnt_w) begin
      mem_addr_w  = bus.cfg_addr;
      mem_wdata_w = bus.cfg_wdata;
    end
  end

  assign bus.cfg_gnt    = cfg_gnt_w;
  assign bus.mem_we     = cfg_gnt_w;
  assign bus.mem_addr   = mem_addr_w;
  assign bus.mem_wdata  = mem_wdata_w;
  assign bus.upd_valid  = (state_q == SWEEP);
  assign bus.upd_idx    = (state_q == SWEEP) ? idx_q : '0;
  assign bus.upd_spikes = upd_spikes_q;
  assign busy           = (state_q != IDLE);

  // Input sync, spike accumulation, tick bookkeeping and per-step sweep/commit registers.
  // A tick coinciding with the IDLE exit re-arms tick_pend instead of counting as lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      acc_q        <= '0;
      upd_spikes_q <= '0;
      tick_pend_q  <= 1'b0;
      overrun      <= 1'b0;
      idx_q        <= '0;
      next_out_q   <= '0;
      spikes_out   <= '0;
      step_cnt     <= '0;
    end else begin
      sync1_q     <= spikes_in;
      sync2_q     <= sync1_q;
      tick_pend_q <= (tick_pend_q && !leave_idle) || tick;
      if (tick && tick_pend_q && !leave_idle) overrun <= 1'b1;

      if (state_q == CAPTURE) begin
        upd_spikes_q <= acc_q | sync2_q;
        acc_q        <= '0;
        next_out_q   <= '0;
        idx_q        <= '0;
      end else begin
        acc_q <= acc_q | sync2_q;
      end

      if (state_q == SWEEP && bus.upd_ready) begin
        next_out_q[idx_q] <= bus.upd_fire;
        if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
      end

      if (state_q == COMMIT) begin
        spikes_out <= next_out_q;
        step_cnt   <= step_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed/randomized bench for snn_step_scheduler with a behavioural step model.
module tb_snn_step_scheduler;
  import snn_pkg::*;

  localparam int unsigned NN = 3;
  localparam int unsigned NI = 3;
  localparam int unsigned PW = 24;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b0;
  logic [PW-1:0] period = '0;
  logic [NI-1:0] spikes_in = '0;
  logic [NN-1:0] spikes_out;
  logic          step_tick;
  logic [7:0]    step_cnt;
  logic          busy, overrun;
  logic          ready_en = 1'b1;
  logic [NN-1:0] fire_pat = '0;

  snn_step_scheduler_if #(.N_NEURONS(NN), .N_INPUTS(NI), .ADDR_W(AW), .DATA_W(DW)) bus();

  assign bus.upd_ready = ready_en;
  assign bus.upd_fire  = fire_pat[bus.upd_idx];

  snn_step_scheduler #(
    .N_NEURONS(NN), .N_INPUTS(NI), .PERIOD_W(PW),
    .DEF_PERIOD(24'd10_000), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .period(period), .spikes_in(spikes_in),
    .bus(bus), .spikes_out(spikes_out), .step_tick(step_tick), .step_cnt(step_cnt),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, n_ticks = 0, n_sweeps = 0, n_gnt = 0, gnt_busy = 0;
  int prev_tick_cyc = 0, last_tick_cyc = 0;
  logic [NI-1:0] last_sweep_spk = '0;

  // Observer on the falling edge: tick times, sweep starts with their frozen spikes, grants.
  always @(negedge clk) begin
    cyc++;
    if (step_tick) begin
      prev_tick_cyc = last_tick_cyc;
      last_tick_cyc = cyc;
      n_ticks++;
    end
    if (bus.upd_valid && bus.upd_ready && bus.upd_idx == '0) begin
      n_sweeps++;
      last_sweep_spk = bus.upd_spikes;
    end
    if (bus.cfg_gnt) begin
      n_gnt++;
      if (busy) gnt_busy++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input string tag, input int k, input int budget);
    int target;
    target = n_ticks + k;
    for (int i = 0; i < budget; i++) begin
      if (n_ticks >= target) break;
      cycle();
    end
    chk(tag, 32'(n_ticks >= target), 32'd1);
  endtask

  task automatic wait_idx1(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.upd_valid && bus.upd_idx == 2'd1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_spk_out"}, 32'(spikes_out), 32'd0);
    chk({tag, "_tick"},    32'(step_tick), 32'd0);
    chk({tag, "_cnt"},     32'(step_cnt), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_ovr"},     32'(overrun), 32'd0);
    chk({tag, "_gnt"},     32'(bus.cfg_gnt), 32'd0);
    chk({tag, "_we"},      32'(bus.mem_we), 32'd0);
    chk({tag, "_maddr"},   32'(bus.mem_addr), 32'd0);
    chk({tag, "_mdata"},   32'(bus.mem_wdata), 32'd0);
    chk({tag, "_valid"},   32'(bus.upd_valid), 32'd0);
    chk({tag, "_idx"},     32'(bus.upd_idx), 32'd0);
    chk({tag, "_uspk"},    32'(bus.upd_spikes), 32'd0);
  endtask

  int base, g0, t0, s0;
  logic [NI-1:0] pat;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  bit seen, prev_st;

  initial begin
    bus.cfg_req   = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    rst_n = 1'b0;
    repeat (3) cycle();
    check_zero("reset");
    rst_n = 1'b1;
    base = n_ticks;

    // 1: period 8, fire 101, then random fire patterns; spacing and step count follow the model.
    period = 24'd8;
    ena = 1'b1;
    fire_pat = 3'b101;
    wait_ticks("t1_first", 1, 40);
    wait_ticks("t1_more", 3, 40);
    chk("t1_space", 32'(last_tick_cyc - prev_tick_cyc), 32'd8);
    chk("t1_out", 32'(spikes_out), 32'b101);
    chk("t1_cnt", 32'(step_cnt), 32'((n_ticks - base) % 256));
    for (int k = 0; k < 5; k++) begin
      fire_pat = NN'($urandom);
      wait_ticks("t1_rwait", 1, 20);
      chk("t1_rnd_out", 32'(spikes_out), 32'(fire_pat));
      chk("t1_rnd_cnt", 32'(step_cnt), 32'((n_ticks - base) % 256));
    end

    // 2: one-cycle spike pulse right after a commit shows up in the next step only.
    for (int k = 0; k < 4; k++) begin
      pat = (k == 0) ? 3'b010 : NI'($urandom_range(1, 7));
      spikes_in = pat;
      cycle();
      spikes_in = '0;
      wait_ticks("t2_w1", 1, 20);
      chk("t2_next", 32'(last_sweep_spk), 32'(pat));
      wait_ticks("t2_w2", 1, 20);
      chk("t2_after", 32'(last_sweep_spk), 32'd0);
    end

    // 3: config request raised mid-sweep is granted once, in the IDLE cycle right after COMMIT.
    wait_idx1("t3_find");
    a = AW'($urandom);
    d = DW'($urandom);
    g0 = n_gnt;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    bus.cfg_req   = 1'b1;
    seen = 1'b0;
    prev_st = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.cfg_gnt) begin
        seen = 1'b1;
        chk("t3_after_commit", 32'(prev_st), 32'd1);
        chk("t3_we", 32'(bus.mem_we), 32'd1);
        chk("t3_addr", 32'(bus.mem_addr), 32'(a));
        chk("t3_data", 32'(bus.mem_wdata), 32'(d));
        break;
      end
      prev_st = step_tick;
    end
    chk("t3_seen", 32'(seen), 32'd1);
    cycle();
    bus.cfg_req = 1'b0;
    repeat (5) cycle();
    chk("t3_once", 32'(n_gnt - g0), 32'd1);
    chk("t3_no_busy_gnt", 32'(gnt_busy), 32'd0);

    // 4: stall the datapath for 20 cycles at period 8; one tick is lost, one extra sweep follows.
    wait_ticks("t4_align", 1, 20);
    chk("t4_pre_ovr", 32'(overrun), 32'd0);
    ready_en = 1'b0;
    repeat (20) cycle();
    chk("t4_ovr", 32'(overrun), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    t0 = n_ticks;
    s0 = n_sweeps;
    ena = 1'b0;
    ready_en = 1'b1;
    repeat (40) cycle();
    chk("t4_ticks", 32'(n_ticks - t0), 32'd2);
    chk("t4_sweeps", 32'(n_sweeps - s0), 32'd2);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_sticky", 32'(overrun), 32'd1);
    ena = 1'b1;

    // 5: period 0 uses the 10000-cycle default; freezing the timer 100 cycles stretches one step.
    period = '0;
    wait_ticks("t5_w", 3, 35000);
    chk("t5_space", 32'(last_tick_cyc - prev_tick_cyc), 32'd10000);
    ena = 1'b0;
    repeat (100) cycle();
    ena = 1'b1;
    wait_ticks("t5_w2", 1, 10200);
    chk("t5_frozen", 32'(last_tick_cyc - prev_tick_cyc), 32'd10100);

    // 6: asynchronous reset mid-sweep clears everything; stepping resumes, step_cnt wraps.
    period = 24'd8;
    wait_ticks("t6_align", 1, 40);
    wait_idx1("t6_find");
    rst_n = 1'b0;
    #1;
    check_zero("t6_rst");
    cycle();
    rst_n = 1'b1;
    base = n_ticks;
    fire_pat = 3'b011;
    wait_ticks("t6_resume", 2, 40);
    chk("t6_out", 32'(spikes_out), 32'b011);
    chk("t6_cnt", 32'(step_cnt), 32'((n_ticks - base) % 256));
    wait_ticks("t6_wrapw", 258, 258 * 8 + 40);
    chk("t6_wrap", 32'(step_cnt), 32'((n_ticks - base) % 256));
    chk("t6_ovr", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
